// File: rtl/keypad_scanner_entry_pkg.sv
// Shared definitions for the keypad scanner / number-entry slice.
// Holds the special key codes, the debounce FSM state encoding, the
// per-frame scan result encoding, and the matrix position -> key code map.
package keypad_defs;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } dbnc_state_t;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_res_t;

  // Key printed at (column, row) of the 4x4 matrix.
  function automatic logic [3:0] key_at(input logic [1:0] col, input logic [1:0] row);
    logic [3:0] k;
    k = 4'h0;
    unique case ({col, row})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h4;
      4'b00_10: k = 4'h7;
      4'b00_11: k = 4'h0;
      4'b01_00: k = 4'h2;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h8;
      4'b01_11: k = 4'hF;
      4'b10_00: k = 4'h3;
      4'b10_01: k = 4'h6;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hE;
      4'b11_00: k = 4'hA;
      4'b11_01: k = 4'hB;
      4'b11_10: k = 4'hC;
      4'b11_11: k = 4'hD;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_entry_editor.sv
// Number editor driven by debounced key presses.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_key_valid         1-cycle pulse for an accepted key
//   i_key_code          code of the accepted key
//   o_edit_value        number being edited (0..9999)
//   o_number_out        value captured on ENTER
//   o_number_valid      1-cycle pulse when o_number_out is updated
module keypad_entry_editor
  import keypad_defs::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_key_valid,
  input  logic [3:0]  i_key_code,
  output logic [15:0] o_edit_value,
  output logic [15:0] o_number_out,
  output logic        o_number_valid
);

  logic [15:0] r_value;
  logic [15:0] r_number;
  logic        r_number_valid;

  logic [9:0]  w_low3;
  logic [13:0] w_shifted;
  logic [15:0] w_div10;

  // Dropping the oldest digit before the shift keeps the result <= 9999,
  // so the shifted value always fits in 14 bits.
  assign w_low3    = 10'(r_value % 16'd1000);
  assign w_shifted = 14'(w_low3) * 14'd10 + 14'(i_key_code);
  assign w_div10   = r_value / 16'd10;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_value        <= '0;
      r_number       <= '0;
      r_number_valid <= 1'b0;
    end else begin
      r_number_valid <= 1'b0;
      if (i_key_valid) begin
        if (i_key_code <= 4'd9) begin
          r_value <= {2'b00, w_shifted};
        end else begin
          unique case (i_key_code)
            KEY_CLEAR: r_value <= '0;
            KEY_BKSP:  r_value <= w_div10;
            KEY_ENTER: begin
              r_number       <= r_value;
              r_number_valid <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign o_edit_value   = r_value;
  assign o_number_out   = r_number;
  assign o_number_valid = r_number_valid;

endmodule

// File: rtl/keypad_scanner_entry.sv
// 4x4 matrix keypad scanner with per-frame debounce and number entry.
// Ports:
//   clock_100Mhz   system clock
//   reset          synchronous active-high reset
//   Row_in[3:0]    keypad rows, active-low, asynchronous
//   Col_drive[3:0] column strobes, active-low one-hot
//   key_code[3:0]  last accepted key
//   key_valid      1-cycle pulse per accepted press
//   edit_value     number being edited (0..9999)
//   number_out     value captured on ENTER
//   number_valid   1-cycle pulse when number_out is updated
module keypad_scanner_entry
  import keypad_defs::*;
#(
  parameter int unsigned SCAN_DIV_BITS   = 16,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic        clock_100Mhz,
  input  logic        reset,
  input  logic [3:0]  Row_in,
  output logic [3:0]  Col_drive,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [15:0] edit_value,
  output logic [15:0] number_out,
  output logic        number_valid
);

  localparam int unsigned PW = SCAN_DIV_BITS + 2;
  localparam logic [3:0]  DF = 4'(DEBOUNCE_FRAMES);

  logic [PW-1:0] r_presc;
  logic [3:0]    r_sync1, r_sync2;
  logic [1:0]    w_col;
  logic          w_sample, w_frame_end;

  logic [1:0]    r_acc_n;     // hits so far this frame, saturating at 2
  logic [3:0]    r_acc_code;  // code of the first hit this frame
  logic [2:0]    w_col_hits;
  logic [3:0]    w_col_code;
  logic [2:0]    w_tot;
  frame_res_t    w_res;
  logic [3:0]    w_res_code;

  dbnc_state_t   r_state, w_state_nxt;
  logic [3:0]    r_cand, w_cand_nxt;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic          w_accept;
  logic          r_key_valid;
  logic [3:0]    r_key_code;

  assign w_col       = r_presc[PW-1 -: 2];
  assign w_sample    = &r_presc[SCAN_DIV_BITS-1:0];
  assign w_frame_end = w_sample && (w_col == 2'd3);
  assign Col_drive   = ~(4'b0001 << w_col);

  // Synchronizer idles high (no row pulled low) out of reset.
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_presc <= '0;
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_presc <= r_presc + PW'(1);
      r_sync1 <= Row_in;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_col_hits = '0;
    w_col_code = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (!r_sync2[r]) begin
        if (w_col_hits == 3'd0) w_col_code = key_at(w_col, 2'(r));
        w_col_hits = w_col_hits + 3'd1;
      end
    end
  end

  // Result includes the column being sampled in the frame-end cycle.
  assign w_tot      = {1'b0, r_acc_n} + w_col_hits;
  assign w_res      = (w_tot == 3'd0) ? FR_NONE : (w_tot == 3'd1) ? FR_SINGLE : FR_MULTI;
  assign w_res_code = (r_acc_n != 2'd0) ? r_acc_code : w_col_code;

  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_acc_n    <= '0;
      r_acc_code <= '0;
    end else if (w_sample) begin
      if (w_frame_end) begin
        r_acc_n    <= '0;
        r_acc_code <= '0;
      end else begin
        r_acc_n <= (w_tot >= 3'd2) ? 2'd2 : w_tot[1:0];
        if (r_acc_n == 2'd0 && w_col_hits != 3'd0) r_acc_code <= w_col_code;
      end
    end
  end

  // Debounce FSM: state register
  always_ff @(posedge clock_100Mhz) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_cnt       <= w_cnt_nxt;
      r_key_valid <= w_accept;
      if (w_accept) r_key_code <= w_cand_nxt;
    end
  end

  // Debounce FSM: next state, advanced once per frame
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    if (w_frame_end) begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_res == FR_SINGLE) begin
            w_cand_nxt  = w_res_code;
            w_cnt_nxt   = 4'd1;
            w_state_nxt = (DEBOUNCE_FRAMES == 1) ? ST_PRESSED : ST_DEBOUNCE;
          end
        end
        ST_DEBOUNCE: begin
          if (w_res == FR_SINGLE && w_res_code == r_cand) begin
            w_cnt_nxt = r_cnt + 4'd1;
            if (w_cnt_nxt == DF) w_state_nxt = ST_PRESSED;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_PRESSED: begin
          if (w_res == FR_NONE) begin
            w_cnt_nxt   = 4'd1;
            w_state_nxt = (DEBOUNCE_FRAMES == 1) ? ST_IDLE : ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (w_res == FR_NONE) begin
            w_cnt_nxt = r_cnt + 4'd1;
            if (w_cnt_nxt == DF) w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_PRESSED;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Debounce FSM: outputs -- a pulse only on entry to PRESSED from the press path
  always_comb begin
    w_accept = 1'b0;
    if (w_frame_end && (r_state == ST_IDLE || r_state == ST_DEBOUNCE) &&
        w_state_nxt == ST_PRESSED)
      w_accept = 1'b1;
  end

  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;

  keypad_entry_editor u_editor (
    .i_clk          (clock_100Mhz),
    .i_rst          (reset),
    .i_key_valid    (r_key_valid),
    .i_key_code     (r_key_code),
    .o_edit_value   (edit_value),
    .o_number_out   (number_out),
    .o_number_valid (number_valid)
  );

endmodule

// File: tb/tb_keypad_scanner_entry.sv
// Directed bench for keypad_scanner_entry with a keypad matrix model and a
// scoreboard of expected key pulses / edit values / entered numbers.
module tb_keypad_scanner_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  Row_in;
  logic [3:0]  Col_drive;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] edit_value;
  logic [15:0] number_out;
  logic        number_valid;

  always #5 clk = ~clk;

  keypad_scanner_entry #(.SCAN_DIV_BITS(2), .DEBOUNCE_FRAMES(2)) dut (
    .clock_100Mhz (clk),
    .reset        (rst),
    .Row_in       (Row_in),
    .Col_drive    (Col_drive),
    .key_code     (key_code),
    .key_valid    (key_valid),
    .edit_value   (edit_value),
    .number_out   (number_out),
    .number_valid (number_valid)
  );

  // Keypad matrix: bit col*4+row set means that key is held down.
  logic [15:0] down = '0;
  always_comb begin
    Row_in = '1;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!Col_drive[c] && down[c*4+r]) Row_in[r] = 1'b0;
  end

  typedef struct {
    logic [3:0]  code;
    logic [15:0] value;
  } exp_t;

  exp_t        key_q[$];
  logic [15:0] num_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned model_v  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pos(input logic [3:0] k);
    case (k)
      4'h1: return 0;  4'h4: return 1;  4'h7: return 2;  4'h0: return 3;
      4'h2: return 4;  4'h5: return 5;  4'h8: return 6;  4'hF: return 7;
      4'h3: return 8;  4'h6: return 9;  4'h9: return 10; 4'hE: return 11;
      4'hA: return 12; 4'hB: return 13; 4'hC: return 14; default: return 15;
    endcase
  endfunction

  function automatic int unsigned ed(input int unsigned v, input logic [3:0] k);
    if (k <= 4'd9) return (v % 1000) * 10 + int'(k);
    if (k == 4'hA) return 0;
    if (k == 4'hB) return v / 10;
    return v;
  endfunction

  // Record what an accepted press of k must produce.
  task automatic expect_key(input logic [3:0] k);
    model_v = ed(model_v, k);
    key_q.push_back('{k, 16'(model_v)});
    if (k == 4'hE) num_q.push_back(16'(model_v));
  endtask

  task automatic press(input logic [3:0] k);
    expect_key(k);
    down = 16'(1) << pos(k);
    repeat (80) @(posedge clk);
    down = '0;
    repeat (64) @(posedge clk);
  endtask

  task automatic sync_frame();
    int unsigned n = 0;
    while (Col_drive !== 4'b0111 && n < 64) begin @(posedge clk); #1; n++; end
    while (Col_drive !== 4'b1110 && n < 64) begin @(posedge clk); #1; n++; end
    if (n >= 64) chk("frame_sync", 32'(Col_drive), 32'(4'b1110));
  endtask

  // Scoreboard monitor
  logic        pend = 1'b0;
  logic [15:0] pend_val;
  exp_t        mon_e;
  always @(negedge clk) begin
    if (pend) begin
      chk("edit_value", 32'(edit_value), 32'(pend_val));
      pend = 1'b0;
    end
    if (key_valid) begin
      if (key_q.size() == 0) chk("spurious_key_valid", 32'(key_valid), 32'(1'b0));
      else begin
        mon_e = key_q.pop_front();
        chk("key_code", 32'(key_code), 32'(mon_e.code));
        pend     = 1'b1;
        pend_val = mon_e.value;
      end
    end
    if (number_valid) begin
      if (num_q.size() == 0) chk("spurious_number_valid", 32'(number_valid), 32'(1'b0));
      else chk("number_out", 32'(number_out), 32'(num_q.pop_front()));
    end
  end

  initial begin
    int unsigned n;
    logic [3:0]  ec;
    logic [3:0]  one;

    // Reset values and column stepping
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_col_drive",    32'(Col_drive),    32'(4'b1110));
    chk("rst_key_code",     32'(key_code),     32'd0);
    chk("rst_key_valid",    32'(key_valid),    32'd0);
    chk("rst_edit_value",   32'(edit_value),   32'd0);
    chk("rst_number_out",   32'(number_out),   32'd0);
    chk("rst_number_valid", 32'(number_valid), 32'd0);
    rst = 1'b0;
    one = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      ec = ~(one << (i / 4));
      chk("col_step", 32'(Col_drive), 32'(ec));
      @(negedge clk);
    end

    // Held key 7: one pulse only
    press(4'h7);
    chk("hold7_drained", key_q.size(), 0);

    // Digit entry with oldest digit dropping
    press(4'hA);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    chk("digits_drained", key_q.size(), 0);

    // Backspace, clear, enter
    press(4'hA);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    press(4'hB);
    press(4'hA);
    press(4'h4); press(4'h2);
    press(4'hE);
    press(4'hC);
    chk("edit_drained",  key_q.size(), 0);
    chk("enter_drained", num_q.size(), 0);

    // Key 5 only in alternate frames
    sync_frame();
    for (int i = 0; i < 4; i++) begin
      down = 16'(1) << pos(4'h5);
      repeat (16) @(posedge clk);
      down = '0;
      repeat (16) @(posedge clk);
    end
    repeat (64) @(posedge clk);

    // Keys 1 and 2 together
    sync_frame();
    down = (16'(1) << pos(4'h1)) | (16'(1) << pos(4'h2));
    repeat (80) @(posedge clk);
    down = '0;
    repeat (64) @(posedge clk);
    chk("bounce_multi_none", key_q.size(), 0);

    // Key 9 released for a single frame does not repeat
    expect_key(4'h9);
    sync_frame();
    down = 16'(1) << pos(4'h9);
    repeat (80) @(posedge clk);
    sync_frame();
    down = '0;
    repeat (16) @(posedge clk);
    down = 16'(1) << pos(4'h9);
    repeat (80) @(posedge clk);
    down = '0;
    repeat (64) @(posedge clk);
    chk("key9_drained", key_q.size(), 0);

    // Reset in the middle of a debounce
    sync_frame();
    down = 16'(1) << pos(4'h3);
    repeat (20) @(posedge clk);
    rst  = 1'b1;
    down = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_v = 0;
    chk("midrst_edit_value", 32'(edit_value), 32'd0);
    chk("midrst_key_valid",  32'(key_valid),  32'd0);
    repeat (64) @(posedge clk);

    // Fresh press accepted after two frames
    sync_frame();
    expect_key(4'h6);
    down = 16'(1) << pos(4'h6);
    n = 0;
    while (!key_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("fresh_press_accepted", 32'(key_valid), 32'd1);
    repeat (64) @(posedge clk);
    down = '0;
    repeat (64) @(posedge clk);

    chk("final_key_q", key_q.size(), 0);
    chk("final_num_q", num_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
